result_trace_fifo: RTL and testbench

RESULT_TRACE_FIFO -- requirements
Module: result_trace_fifo

---
 rtl/result_trace_fifo_if.sv | 23 ++
 rtl/result_trace_fifo.sv | 72 +++++++
 tb/tb_result_trace_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/result_trace_fifo_if.sv
// Capture and read-side handshake bundle for the result trace FIFO.
// master = datapath/consumer side, slave = FIFO side.
interface result_trace_fifo_if;
   logic        cap_en;
   logic [31:0] Instr;
   logic [31:0] Final_out;
   logic [3:0]  Status;
   logic        rd_ready;
   logic        rd_valid;
   logic [31:0] rd_instr;
   logic [31:0] rd_result;
   logic [3:0]  rd_status;

   modport master (
      output cap_en, Instr, Final_out, Status, rd_ready,
      input  rd_valid, rd_instr, rd_result, rd_status
   );

   modport slave (
      input  cap_en, Instr, Final_out, Status, rd_ready,
      output rd_valid, rd_instr, rd_result, rd_status
   );
endinterface

// File: rtl/result_trace_fifo.sv
// Show-ahead trace FIFO capturing {Status, Instr, Final_out} on each RegRW cycle,
// with a sticky overflow flag and saturating drop counter.
module result_trace_fifo #(
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   result_trace_fifo_if.slave       trc,
   input  logic                     clr_ovf,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [67:0]   mem [DEPTH];
   logic          push;
   logic          pop;
   logic          drop;

   // Flags come from count alone so a full ring never aliases as empty.
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

   assign pop  = trc.rd_valid && trc.rd_ready;
   assign push = trc.cap_en && (!full || pop);
   assign drop = trc.cap_en && full && !pop;

   assign trc.rd_valid  = !empty;
   assign trc.rd_status = mem[rd_ptr][67:64];
   assign trc.rd_instr  = mem[rd_ptr][63:32];
   assign trc.rd_result = mem[rd_ptr][31:0];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {trc.Status, trc.Instr, trc.Final_out};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A drop coincident with clr_ovf restarts the tally at one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (clr_ovf)             drop_cnt <= 8'd1;
         else if (drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end
   end
endmodule

// File: tb/tb_result_trace_fifo.sv
// Directed + randomized bench for result_trace_fifo against a queue-based model.
module tb_result_trace_fifo;
   localparam int unsigned DEPTH = 16;

   typedef struct packed {
      logic [3:0]  st;
      logic [31:0] ins;
      logic [31:0] res;
   } ent_t;

   logic       clk;
   logic       reset;
   logic       clr_ovf;
   logic [4:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic [7:0] drop_cnt;

   result_trace_fifo_if bus ();

   result_trace_fifo #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .trc      (bus),
      .clr_ovf  (clr_ovf),
      .count    (count),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   ent_t q[$];
   logic m_ovf = 1'b0;
   int   m_drop = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"},    64'(count),        64'(q.size()));
      chk({tag, ".empty"},    64'(empty),        64'(q.size() == 0));
      chk({tag, ".full"},     64'(full),         64'(q.size() == DEPTH));
      chk({tag, ".rd_valid"}, 64'(bus.rd_valid), 64'(q.size() != 0));
      chk({tag, ".overflow"}, 64'(overflow),     64'(m_ovf));
      chk({tag, ".drop_cnt"}, 64'(drop_cnt),     64'(m_drop));
      if (q.size() != 0) begin
         chk({tag, ".instr"},  64'(bus.rd_instr),  64'(q[0].ins));
         chk({tag, ".result"}, 64'(bus.rd_result), 64'(q[0].res));
         chk({tag, ".status"}, 64'(bus.rd_status), 64'(q[0].st));
      end
   endtask

   // Called at a negedge: drive inputs, let one rising edge pass, update model, check.
   task automatic step(input string tag, input logic cap, input logic [31:0] ins,
                       input logic [31:0] res, input logic [3:0] st,
                       input logic rdy, input logic clr);
      logic pop_m, push_m, drop_m, full_m;
      ent_t e;
      bus.cap_en    = cap;
      bus.Instr     = ins;
      bus.Final_out = res;
      bus.Status    = st;
      bus.rd_ready  = rdy;
      clr_ovf       = clr;
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() != 0) && rdy;
      push_m = cap && (!full_m || pop_m);
      drop_m = cap && full_m && !pop_m;
      @(posedge clk);
      @(negedge clk);
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
         e = {st, ins, res};
         q.push_back(e);
      end
      if (drop_m) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
      end else if (clr) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
      check_state(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] first_res;
      reset = 1'b0;
      clr_ovf = 1'b0;
      bus.cap_en = 1'b0;
      bus.Instr = '0;
      bus.Final_out = '0;
      bus.Status = '0;
      bus.rd_ready = 1'b0;
      #1;
      check_state("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Three pushes then in-order drain
      step("p11", 1'b1, 32'h1000_0001, 32'h11, 4'h1, 1'b0, 1'b0);
      step("p22", 1'b1, 32'h1000_0002, 32'h22, 4'h2, 1'b0, 1'b0);
      step("p33", 1'b1, 32'h1000_0003, 32'h33, 4'h3, 1'b0, 1'b0);
      chk("seq.head0", 64'(bus.rd_result), 64'h11);
      step("d1", 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("seq.head1", 64'(bus.rd_result), 64'h22);
      step("d2", 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("seq.head2", 64'(bus.rd_result), 64'h33);
      step("d3", 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("seq.valid_end", 64'(bus.rd_valid), 64'h0);

      // Push with rd_ready on an empty FIFO
      step("empty_push", 1'b1, 32'hCAFE_0001, 32'hBEEF_0001, 4'h9, 1'b1, 1'b0);
      chk("empty_push.count", 64'(count), 64'h1);
      step("empty_drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);

      // Twenty captures into a 16-deep FIFO
      first_res = $urandom;
      step("fill0", 1'b1, $urandom, first_res, 4'($urandom), 1'b0, 1'b0);
      for (int i = 1; i < 20; i++)
         step("fill", 1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
      chk("fill.count", 64'(count), 64'd16);
      chk("fill.drop_cnt", 64'(drop_cnt), 64'd4);
      chk("fill.head", 64'(bus.rd_result), 64'(first_res));

      // Full-rate streaming while full
      step("clr", 1'b0, '0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++)
         step("stream", 1'b1, $urandom, $urandom, 4'($urandom), 1'b1, 1'b0);
      chk("stream.count", 64'(count), 64'd16);
      chk("stream.drop_cnt", 64'(drop_cnt), 64'd0);

      // Saturation, then clear coincident with a drop
      for (int i = 0; i < 300; i++)
         step("sat", 1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
      chk("sat.drop_cnt", 64'(drop_cnt), 64'd255);
      step("clr_drop", 1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b1);
      chk("clr_drop.overflow", 64'(overflow), 64'd1);
      chk("clr_drop.drop_cnt", 64'(drop_cnt), 64'd1);

      // Random traffic
      for (int i = 0; i < 250; i++)
         step("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
              1'($urandom), ($urandom_range(0, 15) == 0));

      // Drain, store five, then asynchronous mid-cycle reset
      for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++)
         step("drain", 1'b0, '0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++)
         step("five", 1'b1, $urandom, $urandom, 4'($urandom), 1'b0, 1'b0);
      chk("five.count", 64'(count), 64'd5);
      #2;
      reset = 1'b0;
      #1;
      q.delete();
      m_ovf = 1'b0;
      m_drop = 0;
      check_state("async_rst");
      @(negedge clk);
      reset = 1'b1;
      step("post_rst", 1'b1, 32'hABCD_0013, 32'h0000_5555, 4'h5, 1'b0, 1'b0);
      chk("post_rst.instr", 64'(bus.rd_instr), 64'hABCD_0013);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
